// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
package hazard_pkg;

  // EX-stage operand source selects
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // resultsrc encoding that marks a load in flight
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Memory-wait freeze FSM states
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } memwait_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Forwarding select for one EX-stage source operand.
// The result in M is younger than the one in W, so M wins when both match.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output fwd_sel_t   forwardE
);

  // Pick the youngest in-flight producer of rsE; x0 is never forwarded
  always_comb begin
    forwardE = FWD_RF;
    if (regwriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      forwardE = FWD_MEM;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      forwardE = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the pipelined RISC-V core.
// Produces forwarding selects, stalls and flushes, freezes the whole
// pipeline while the data memory in M is not ready, flags a sticky error
// when a memory wait exceeds TIMEOUT cycles and counts stall cycles.
// Optional macro HAZARD_PERF_EN adds flush and load-use cycle counters;
// without it flush_cnt and loaduse_cnt are tied to zero.
// state_dbg / wait_cnt_dbg expose the memory-wait FSM for observation.
//
// Handshake: the memory access in M is the only valid/ready pair here.
// memaccessM acts as valid, memreadyM as ready; the access completes in
// the cycle both are high, and every cycle with valid high and ready low
// holds F/D/E/M and bubbles W. Stalls come straight from that comparison,
// so an access that is ready at once costs no cycle.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1D,
  input  logic [4:0]           rs2D,
  input  logic [4:0]           rs1E,
  input  logic [4:0]           rs2E,
  input  logic [4:0]           rdE,
  input  logic [1:0]           resultsrcE,
  input  logic                 pcsrcE,
  input  logic [4:0]           rdM,
  input  logic [4:0]           rdW,
  input  logic                 regwriteM,
  input  logic                 regwriteW,
  input  logic                 memaccessM,
  input  logic                 memreadyM,
  output logic [1:0]           forwardAE,
  output logic [1:0]           forwardBE,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushW,
  output logic                 err,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     loaduse_cnt,
  output memwait_state_t       state_dbg,
  output logic [WAIT_W-1:0]    wait_cnt_dbg
);

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic     lwstall;
  logic     memstall;

  memwait_state_t    state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              err_next;

  forward_unit u_fwd_a (
    .rsE       (rs1E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardE  (fwd_a)
  );

  forward_unit u_fwd_b (
    .rsE       (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardE  (fwd_b)
  );

  assign forwardAE = fwd_a;
  assign forwardBE = fwd_b;

  // Hazard detection: load-use on decode sources, and memory not ready
  always_comb begin
    lwstall  = (resultsrcE == RESULTSRC_LOAD) && (rdE != 5'd0) &&
               ((rdE == rs1D) || (rdE == rs2D));
    memstall = memaccessM && !memreadyM;
  end

  // Stall/flush outputs; a memory wait freezes everything and defers any
  // branch or load-use action until E is released and re-evaluated
  always_comb begin
    stallF = lwstall;
    stallD = lwstall;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = pcsrcE;
    flushE = lwstall | pcsrcE;
    flushW = 1'b0;
    if (memstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushD = 1'b0;
      flushE = 1'b0;
      flushW = 1'b1;
    end
  end

  // Memory-wait FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      err      <= err_next;
    end
  end

  // Next-state: count consecutive wait cycles, saturating at TIMEOUT
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    err_next   = err;
    case (state)
      RUN: begin
        if (memstall) begin
          state_next = WAIT;
          wait_next  = WAIT_ONE;
        end
      end
      WAIT: begin
        if (memstall) begin
          if (wait_cnt == TIMEOUT_V) begin
            err_next = 1'b1;
          end else begin
            wait_next = wait_cnt + WAIT_ONE;
          end
        end else begin
          state_next = RUN;
          wait_next  = '0;
        end
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  assign state_dbg    = state;
  assign wait_cnt_dbg = wait_cnt;

  // Saturating count of cycles in which fetch is held
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stallF && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counts of taken-branch flushes and load-use stalls,
  // ignoring cycles frozen by a memory wait
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt   <= '0;
      loaduse_cnt <= '0;
    end else begin
      if (pcsrcE && !memstall && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
      if (lwstall && !memstall && (loaduse_cnt != CNT_MAX)) begin
        loaduse_cnt <= loaduse_cnt + CNT_ONE;
      end
    end
  end
`else
  assign flush_cnt   = '0;
  assign loaduse_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int WAIT_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] resultsrcE;
  logic       pcsrcE, regwriteM, regwriteW, memaccessM, memreadyM;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, err;
  logic [CNT_W-1:0]  stall_cycles, flush_cnt, loaduse_cnt;
  memwait_state_t    state_dbg;
  logic [WAIT_W-1:0] wait_cnt_dbg;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .rdM(rdM), .rdW(rdW),
    .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memaccessM(memaccessM), .memreadyM(memreadyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .err(err),
    .stall_cycles(stall_cycles), .flush_cnt(flush_cnt),
    .loaduse_cnt(loaduse_cnt), .state_dbg(state_dbg),
    .wait_cnt_dbg(wait_cnt_dbg)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int m_run  = 0;   // consecutive cycles the memory has been waited on
  bit m_err  = 0;
  int m_sc   = 0;
  int m_fc   = 0;
  int m_lc   = 0;
  logic [10:0] exp_q[$];

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_lw();
    return (resultsrcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
  endfunction

  function automatic bit ref_ms();
    return memaccessM && !memreadyM;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected combinational vector: fwdA, fwdB, stallF/D/E/M, flushD/E/W
  task automatic push_comb_expect();
    bit lw, ms;
    logic [6:0] ctl;
    lw = ref_lw();
    ms = ref_ms();
    if (ms) ctl = 7'b1111_001;
    else    ctl = {lw, lw, 1'b0, 1'b0, pcsrcE, lw | pcsrcE, 1'b0};
    exp_q.push_back({ref_fwd(rs1E), ref_fwd(rs2E), ctl});
  endtask

  task automatic check_comb();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("forwardAE", forwardAE, e[10:9]);
    chk("forwardBE", forwardBE, e[8:7]);
    chk("stallF", stallF, e[6]);
    chk("stallD", stallD, e[5]);
    chk("stallE", stallE, e[4]);
    chk("stallM", stallM, e[3]);
    chk("flushD", flushD, e[2]);
    chk("flushE", flushE, e[1]);
    chk("flushW", flushW, e[0]);
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic model_edge();
    bit lw, ms;
    lw = ref_lw();
    ms = ref_ms();
    if (reset) begin
      m_run = 0; m_err = 0; m_sc = 0; m_fc = 0; m_lc = 0;
    end else begin
      if (ms) begin
        if (m_run < 1000) m_run++;
        if (m_run > TIMEOUT) m_err = 1;
      end else begin
        m_run = 0;
      end
      if (ms || lw) m_sc = sat_inc(m_sc);
      if (pcsrcE && !ms) m_fc = sat_inc(m_fc);
      if (lw && !ms) m_lc = sat_inc(m_lc);
    end
  endtask

  task automatic check_regs();
    chk("err", err, m_err);
    chk("state", state_dbg, (m_run != 0) ? WAIT : RUN);
    chk("wait_cnt", wait_cnt_dbg, (m_run < TIMEOUT) ? m_run : TIMEOUT);
    chk("stall_cycles", stall_cycles, m_sc);
`ifdef HAZARD_PERF_EN
    chk("flush_cnt", flush_cnt, m_fc);
    chk("loaduse_cnt", loaduse_cnt, m_lc);
`else
    chk("flush_cnt", flush_cnt, 0);
    chk("loaduse_cnt", loaduse_cnt, 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultsrcE = 0; pcsrcE = 0; regwriteM = 0; regwriteW = 0;
    memaccessM = 0; memreadyM = 1;
  endtask

  // One cycle: check combinational outputs, clock, check registered state
  task automatic step();
    #1;
    push_comb_expect();
    check_comb();
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic randomize_inputs();
    rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
    rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
    rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
    rdW  = 5'($urandom_range(0, 3));
    resultsrcE = 2'($urandom_range(0, 3));
    pcsrcE     = ($urandom_range(0, 3) == 0);
    regwriteM  = 1'($urandom_range(0, 1));
    regwriteW  = 1'($urandom_range(0, 1));
    memaccessM = 1'($urandom_range(0, 1));
    memreadyM  = ($urandom_range(0, 3) != 0);
    reset      = ($urandom_range(0, 63) == 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int hold;
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    step();
    chk("rst_err", err, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_state", state_dbg, RUN);
    reset = 0;

    // forwarding priority
    rs1E = 5; regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5;
    #1 chk("fwd_mem", forwardAE, 2'b10);
    step();
    regwriteM = 0;
    #1 chk("fwd_wb", forwardAE, 2'b01);
    step();
    regwriteM = 1; rdM = 0; rdW = 0; rs1E = 0;
    #1 chk("fwd_x0", forwardAE, 2'b00);
    step();

    // load-use
    idle();
    resultsrcE = 2'b01; rdE = 7; rs2D = 7;
    #1;
    chk("lu_stallF", stallF, 1);
    chk("lu_flushE", flushE, 1);
    chk("lu_flushD", flushD, 0);
    step();
    chk("lu_stall_cycles", stall_cycles, 1);

    // taken branch
    idle();
    pcsrcE = 1;
    #1;
    chk("br_flushD", flushD, 1);
    chk("br_stallF", stallF, 0);
    step();
`ifdef HAZARD_PERF_EN
    chk("br_flush_cnt", flush_cnt, 1);
`endif

    // load-use together with branch
    resultsrcE = 2'b01; rdE = 3; rs1D = 3;
    #1;
    chk("lubr_flushD", flushD, 1);
    chk("lubr_stallD", stallD, 1);
    step();

    // memory wait with branch pending
    idle();
    pcsrcE = 1; memaccessM = 1; memreadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stallE", stallE, 1);
      chk("mw_flushE", flushE, 0);
      step();
      chk("mw_state", state_dbg, WAIT);
    end
    memreadyM = 1;
    #1 chk("mw_release_flushE", flushE, 1);
    step();
    chk("mw_release_state", state_dbg, RUN);
    chk("mw_release_err", err, 0);

    // timeout
    idle();
    memaccessM = 1; memreadyM = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("to_err", err, (i >= TIMEOUT) ? 1 : 0);
    end
    memreadyM = 1;
    step();
    chk("to_err_sticky", err, 1);
    reset = 1;
    step();
    reset = 0;
    chk("to_rst_err", err, 0);
    chk("to_rst_stall_cycles", stall_cycles, 0);

    // reset in the middle of a wait
    memaccessM = 1; memreadyM = 0;
    step();
    step();
    reset = 1;
    #1 chk("rw_stallF_comb", stallF, 1);
    step();
    chk("rw_state", state_dbg, RUN);
    chk("rw_wait_cnt", wait_cnt_dbg, 0);
    reset = 0;
    idle();
    step();

    // random traffic, with occasional long memory waits
    for (int n = 0; n < 1500; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 99) == 0) begin
        hold = $urandom_range(1, 8);
        for (int k = 0; k < hold; k++) begin
          memaccessM = 1; memreadyM = 0; reset = 0;
          step();
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
